demux_14: RTL and testbench

Registered 1-to-4 demultiplexer. Routes data input `I` to the output lane selected by `S` and drives every unselected lane to zero. Output is captured on the clock edge, so downstream logic sees a glitch-free, one-hot-routed bus. Used as a small routing/steering stage wherever one source fans out to four sinks.

---
 rtl/demux_pkg.sv | 19 +
 rtl/onehot_decoder.sv | 25 ++
 rtl/demux_14.sv | 67 ++++++
 tb/tb_demux_14.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the registered 1-to-N demultiplexer.
//
//   SEL_W       default select width (4 lanes)
//   lane_count  number of output lanes for a given select width
//   sel_t       select type at the default width
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic int unsigned lane_count(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
//   Combinational binary-to-one-hot decode. Exactly one output bit is set for
//   every select value; all select codes are legal.
//
//   Ports:
//     sel     input   SEL_W   binary lane select
//     onehot  output  N_OUT   one-hot lane enables, bit k set when sel == k
// -----------------------------------------------------------------------------
module onehot_decoder
    import demux_pkg::*;
#(
    parameter int unsigned SEL_W = demux_pkg::SEL_W,
    parameter int unsigned N_OUT = lane_count(SEL_W)
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/demux_14.sv
// -----------------------------------------------------------------------------
// demux_14
//   Registered 1-to-4 demultiplexer. The data input is steered to the lane
//   chosen by the select and every other lane is driven to zero. The whole
//   output bus comes straight from flops, so downstream logic sees one clean
//   update per clock with no combinational path from I/S to Y.
//
//   Parameters:
//     DATA_W  width of one data lane
//     SEL_W   select width; lane count N_OUT = 2**SEL_W
//
//   Ports:
//     clk  input   1             clock, rising-edge active
//     rst  input   1             asynchronous active-high reset, clears Y
//     I    input   DATA_W        data to route
//     S    input   SEL_W         lane select, unsigned binary
//     Y    output  N_OUT*DATA_W  lane k at Y[k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module demux_14 #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned SEL_W  = demux_pkg::SEL_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_W-1:0]                      I,
    input  logic [SEL_W-1:0]                       S,
    output logic [demux_pkg::lane_count(SEL_W)*DATA_W-1:0] Y
);

    import demux_pkg::*;

    localparam int unsigned N_OUT = lane_count(SEL_W);

    logic [N_OUT-1:0]        lane_en;
    logic [N_OUT*DATA_W-1:0] y_d;
    logic [N_OUT*DATA_W-1:0] y_q;

    onehot_decoder #(
        .SEL_W (SEL_W),
        .N_OUT (N_OUT)
    ) u_decoder (
        .sel    (S),
        .onehot (lane_en)
    );

    // Gate the shared data onto each lane with that lane's decode bit, so
    // unselected lanes are forced to zero rather than holding stale data.
    always_comb begin
        y_d = '0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            y_d[k*DATA_W +: DATA_W] = {DATA_W{lane_en[k]}} & I;
        end
    end

    // Single register for the whole bus: I and S are sampled together, so a
    // simultaneous change of both moves atomically with no intermediate lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_demux_14.sv
module tb_demux_14;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       I   = 1'b0;
    logic [1:0] S   = 2'd0;
    logic [3:0] Y;

    int total = 0;
    int bad   = 0;

    logic [3:0] sb[$];
    logic [3:0] exp_y;

    demux_14 #(
        .DATA_W (1),
        .SEL_W  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .I   (I),
        .S   (S),
        .Y   (Y)
    );

    always #5 clk = ~clk;

    // Reference: selected lane carries I, every other lane is zero.
    function automatic logic [3:0] model(input logic i, input logic [1:0] s);
        logic [3:0] r;
        r = 4'b0000;
        r[s] = i;
        return r;
    endfunction

    // Drive one pair, record what the DUT owes after the next edge, and wait
    // until just after that edge.
    task automatic drive_cycle(input logic i, input logic [1:0] s);
        I = i;
        S = s;
        sb.push_back(model(i, s));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 2'd2);
        exp_y = sb.pop_front();
        total++;
        if (Y !== exp_y) begin
            bad++;
            $display("FAIL reset_pre: Y=%b expected %b", Y, exp_y);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (Y !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async: Y=%b expected 0000", Y);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            total++;
            if (Y !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold edge %0d: Y=%b expected 0000", n, Y);
            end
        end
        sb.delete();
        rst = 1'b0;
        I   = 1'b0;
        S   = 2'd0;
    endtask

    task automatic test_idle();
        drive_cycle(1'b0, 2'd0);
        exp_y = sb.pop_front();
        total++;
        if (Y !== exp_y) begin
            bad++;
            $display("FAIL idle: Y=%b expected %b", Y, exp_y);
        end
    endtask

    task automatic test_sweep();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 3; c++) begin
                drive_cycle(1'b1, 2'(s));
                exp_y = sb.pop_front();
                total++;
                if (Y !== exp_y) begin
                    bad++;
                    $display("FAIL sweep s=%0d cyc=%0d: Y=%b expected %b", s, c, Y, exp_y);
                end
            end
        end
    endtask

    task automatic test_latency();
        drive_cycle(1'b1, 2'd1);
        drive_cycle(1'b1, 2'd1);
        sb.delete();
        // Change both inputs together; Y must not move until the next edge.
        I = 1'b0;
        S = 2'd3;
        #1;
        total++;
        if (Y !== 4'b0010) begin
            bad++;
            $display("FAIL latency_before: Y=%b expected 0010", Y);
        end
        @(negedge clk);
        total++;
        if (Y !== 4'b0010) begin
            bad++;
            $display("FAIL latency_mid: Y=%b expected 0010", Y);
        end
        drive_cycle(1'b0, 2'd3);
        exp_y = sb.pop_front();
        total++;
        if (Y !== exp_y) begin
            bad++;
            $display("FAIL latency_after: Y=%b expected %b", Y, exp_y);
        end
    endtask

    task automatic test_mid_reset();
        drive_cycle(1'b1, 2'd3);
        drive_cycle(1'b1, 2'd3);
        exp_y = sb.pop_front();
        exp_y = sb.pop_front();
        total++;
        if (Y !== exp_y) begin
            bad++;
            $display("FAIL midrst_pre: Y=%b expected %b", Y, exp_y);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (Y !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_async: Y=%b expected 0000", Y);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (Y !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_release: Y=%b expected 0000", Y);
        end
        drive_cycle(1'b1, 2'd3);
        exp_y = sb.pop_front();
        total++;
        if (Y !== exp_y) begin
            bad++;
            $display("FAIL midrst_resume: Y=%b expected %b", Y, exp_y);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [6];
        seq = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
        for (int n = 0; n < 6; n++) begin
            drive_cycle(1'b1, seq[n]);
            exp_y = sb.pop_front();
            total++;
            if (Y !== exp_y) begin
                bad++;
                $display("FAIL b2b step %0d s=%0d: Y=%b expected %b", n, seq[n], Y, exp_y);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] combo [8];
        logic [2:0] tmp;
        int         j;
        for (int n = 0; n < 8; n++) combo[n] = 3'(n);
        for (int n = 7; n > 0; n--) begin
            j        = int'($urandom_range(n, 0));
            tmp      = combo[n];
            combo[n] = combo[j];
            combo[j] = tmp;
        end
        for (int n = 0; n < 8; n++) begin
            drive_cycle(combo[n][2], combo[n][1:0]);
            exp_y = sb.pop_front();
            total++;
            if (Y !== exp_y) begin
                bad++;
                $display("FAIL exhaust I=%b S=%0d: Y=%b expected %b",
                         combo[n][2], combo[n][1:0], Y, exp_y);
            end
            total++;
            if ($countones(Y) > 1) begin
                bad++;
                $display("FAIL onehot I=%b S=%0d: Y=%b expected at most one bit set",
                         combo[n][2], combo[n][1:0], Y);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sweep();
        test_latency();
        test_mid_reset();
        test_back_to_back();
        test_exhaustive();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: run did not finish, expected completion by 50000");
        $fatal(1, "timeout");
    end

endmodule
